instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Streaming MIPS instruction encoder and instruction-memory loader: the inverse of the opcode decoder in the controller.
- Accepts symbolic instruction requests (kind plus register/immediate fields) over a valid/ready handshake.
- Packs each request into a 32-bit MIPS word and writes it to consecutive instruction-memory word addresses.
- Used by the test harness and boot path to populate IM before the single-cycle core runs.

Parameters:
ADDR_W, 10, IM word-address width; capacity DEPTH = 2^ADDR_W words
BASE_ADDR, 0, first word address written after reset/clear

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous restart: pointer to BASE_ADDR, flags cleared
in_valid  input  1  request valid
in_ready  output  1  encoder can accept a request this cycle
kind  input  4  0 addu, 1 subu, 2 lw, 3 sw, 4 beq, 5 lui, 6 ori, 7 jal, 8 jr; 9-15 illegal
rs  input  5  source register field
rt  input  5  target register field
rd  input  5  destination register field (R-type only)
imm  input  16  immediate / offset field
target  input  26  jal word target field
im_we  output  1  IM write strobe, one cycle per word
im_addr  output  ADDR_W  IM word address
im_wdata  output  32  encoded instruction word
count  output  ADDR_W+1  words written since reset/clear
full  output  1  count == DEPTH
err  output  1  sticky: an illegal kind was accepted

Behaviour:
- Reset (reset=0, asynchronous): im_we=0, im_addr=BASE_ADDR, im_wdata=0, count=0, full=0, err=0, state=IDLE.
- Encodings:
  - addu = {000000,rs,rt,rd,00000,100001}; subu funct 100011; jr = {000000,rs,15'b0,001000}.
  - lw op 100011, sw op 101011, beq op 000100, lui op 001111 (rs=0), ori op 001101; all {op,rs,rt,imm}.
  - jal = {000011,target}.
  - Unused fields are ignored.
- Handshake: a request is accepted when in_valid && in_ready. in_ready = (state==IDLE) && !full && !clear.
- Latency 1 cycle: on accept, the next cycle has im_we=1, im_wdata=encoded word, im_addr=current pointer. Pointer and count increment by 1 at that same edge.
- Back-to-back accepts are allowed every cycle, giving one word per cycle.
- im_we is high for exactly one cycle per word. im_addr and im_wdata hold their last values while im_we=0.
- Illegal kind:
  - The handshake still completes; no write occurs.
  - Pointer and count are unchanged; err is set and stays set until reset or clear.
- Full:
  - When count reaches DEPTH, full=1 and in_ready=0.
  - Requests stall; nothing is dropped or overwritten.
  - Pointer wrap is never reached.
- clear:
  - Has priority over an accept in the same cycle; that request is not accepted.
  - Next cycle: pointer=BASE_ADDR, count=0, full=0, err=0, im_we=0, state=IDLE.
  - A clear during a PAD cycle abandons the pad.
- States:
  - IDLE: accepting.
  - PAD: delay-slot insert (optional feature only).
  - Without the optional feature the FSM stays in IDLE.

Optional Feature:
- Macro: INSTR_ENCODER_DELAY_SLOT_NOP_EN.
- Defined:
  - After a legal beq, jal or jr is accepted, the FSM enters PAD for one cycle with in_ready=0.
  - The cycle after the branch write, PAD writes im_wdata=32'h00000000 at the next address (im_we=1), and count increments again.
  - FSM then returns to IDLE.
  - A branch is accepted only if at least 2 words are free; with exactly 1 word free, in_ready=0 for branch kinds and non-branch kinds are still accepted.
  - in_ready therefore depends combinationally on kind in this mode.
- Undefined: no padding, PAD state unreachable, in_ready independent of kind.

Test Plan:
1. Reset, then back-to-back addu rs=1 rt=2 rd=3; ori rs=0 rt=1 imm=0x1234; lui rt=2 imm=0xABCD -> writes 0x00221821@0, 0x34011234@1, 0x3C02ABCD@2 on consecutive cycles; count=3.
2. lw rs=29 rt=4 imm=8; beq rs=1 rt=2 imm=0xFFFF; jal target=0x0C00; jr rs=31 -> 0x8FA40008, 0x1022FFFF, 0x0C000C00, 0x03E00008 at addresses 0-3.
3. kind=12 accepted between two ori requests -> err=1, no write, second ori lands at address 1; clear -> err=0, count=0, next write at BASE_ADDR.
4. ADDR_W=2: send 5 requests with in_valid held -> 4 writes, full=1, in_ready=0, 5th held; clear asserted together with in_valid -> no accept that cycle, accept proceeds after.
5. Assert reset mid-stream with im_we=1 -> all outputs return to reset values immediately, without waiting for a clock edge.
6. With INSTR_ENCODER_DELAY_SLOT_NOP_EN: beq then addu -> beq@0, 0x00000000@1, addu@2, in_ready=0 during PAD; ADDR_W=2 with 3 words used, beq stalls while ori is accepted.

Source files
------------

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder / IM loader.
// Optional delay-slot NOP padding: INSTR_ENCODER_DELAY_SLOT_NOP_EN.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic {
    IDLE = 1'b0,
    PAD  = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] DEPTH =
    (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE =
    ADDR_W'(BASE_ADDR);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;

  logic [31:0] enc;
  logic        legal;
  logic        accept;
  logic        idle_ok;

  // Pack the symbolic request into a MIPS word
  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (kind)
      4'd0: enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100001};
      4'd1: enc = {6'b000000, rs, rt, rd, 5'b0, 6'b100011};
      4'd2: enc = {6'b100011, rs, rt, imm};
      4'd3: enc = {6'b101011, rs, rt, imm};
      4'd4: enc = {6'b000100, rs, rt, imm};
      4'd5: enc = {6'b001111, 5'b0, rt, imm};
      4'd6: enc = {6'b001101, rs, rt, imm};
      4'd7: enc = {6'b000011, target};
      4'd8: enc = {6'b000000, rs, 15'b0, 6'b001000};
      default: legal = 1'b0;
    endcase
  end

  assign full    = (cnt_q == DEPTH);
  assign idle_ok = (state_q == IDLE) && !full && !clear;

`ifdef INSTR_ENCODER_DELAY_SLOT_NOP_EN
  logic            is_br;
  logic [ADDR_W:0] free;
  assign is_br = (kind == 4'd4) || (kind == 4'd7) ||
                 (kind == 4'd8);
  assign free  = DEPTH - cnt_q;
  // A branch needs room for itself plus its delay-slot NOP
  assign in_ready = idle_ok &&
    !(is_br && (free < (ADDR_W+1)'(2)));
`else
  assign in_ready = idle_ok;
`endif

  assign accept = in_valid && in_ready;

  // Next-state: clear wins, then pad write, then accept
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = err_q;
    if (clear) begin
      state_d = IDLE;
      ptr_d   = BASE;
      cnt_d   = '0;
      err_d   = 1'b0;
`ifdef INSTR_ENCODER_DELAY_SLOT_NOP_EN
    end else if (state_q == PAD) begin
      we_d    = 1'b1;
      addr_d  = ptr_q;
      wdata_d = 32'h0000_0000;
      ptr_d   = ptr_q + 1'b1;
      cnt_d   = cnt_q + 1'b1;
      state_d = IDLE;
`endif
    end else if (accept) begin
      if (legal) begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = enc;
        ptr_d   = ptr_q + 1'b1;
        cnt_d   = cnt_q + 1'b1;
`ifdef INSTR_ENCODER_DELAY_SLOT_NOP_EN
        if (is_br) state_d = PAD;
`endif
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= BASE;
      addr_q  <= BASE;
      cnt_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign count    = cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder.
// DUT a: ADDR_W=10, DUT b: ADDR_W=2.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_clr = 1'b0, b_clr = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0]  kind = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] tgt = '0;

  logic        a_rdy, a_we, a_full, a_err;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic [10:0] a_cnt;

  logic        b_rdy, b_we, b_full, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [2:0]  b_cnt;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) u_a (
    .clk(clk), .reset(reset), .clear(a_clr),
    .in_valid(a_valid), .in_ready(a_rdy),
    .kind(kind), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .target(tgt),
    .im_we(a_we), .im_addr(a_addr),
    .im_wdata(a_wdata), .count(a_cnt),
    .full(a_full), .err(a_err)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) u_b (
    .clk(clk), .reset(reset), .clear(b_clr),
    .in_valid(b_valid), .in_ready(b_rdy),
    .kind(kind), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .target(tgt),
    .im_we(b_we), .im_addr(b_addr),
    .im_wdata(b_wdata), .count(b_cnt),
    .full(b_full), .err(b_err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic req(input logic [3:0] k,
                     input logic [4:0] s,
                     input logic [4:0] t,
                     input logic [4:0] d,
                     input logic [15:0] i,
                     input logic [25:0] g);
    kind = k; rs = s; rt = t; rd = d;
    imm = i; tgt = g;
  endtask

  task automatic chk_a_wr(input string tag,
                          input logic [9:0] ad,
                          input logic [31:0] wd);
    chk({tag, "_we"}, 64'(a_we), 64'(1'b1));
    chk({tag, "_addr"}, 64'(a_addr), 64'(ad));
    chk({tag, "_data"}, 64'(a_wdata), 64'(wd));
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_we", 64'(a_we), 64'd0);
    chk("rst_addr", 64'(a_addr), 64'd0);
    chk("rst_wdata", 64'(a_wdata), 64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    chk("rst_full", 64'(a_full), 64'd0);
    chk("rst_err", 64'(a_err), 64'd0);
    chk("rst_b_cnt", 64'(b_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: addu, ori, lui back to back
    @(negedge clk);
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    a_valid = 1'b1;
    #1 chk("t1_rdy", 64'(a_rdy), 64'd1);
    @(negedge clk);
    chk_a_wr("t1_addu", 10'd0, 32'h0022_1821);
    req(4'd6, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0);
    @(negedge clk);
    chk_a_wr("t1_ori", 10'd1, 32'h3401_1234);
    req(4'd5, 5'd0, 5'd2, 5'd0, 16'hABCD, 26'h0);
    @(negedge clk);
    chk_a_wr("t1_lui", 10'd2, 32'h3C02_ABCD);
    a_valid = 1'b0;
    @(negedge clk);
    chk("t1_we_off", 64'(a_we), 64'd0);
    chk("t1_addr_hold", 64'(a_addr), 64'd2);
    chk("t1_data_hold", 64'(a_wdata), 64'h3C02_ABCD);
    chk("t1_cnt", 64'(a_cnt), 64'd3);

`ifndef INSTR_ENCODER_DELAY_SLOT_NOP_EN
    // 2: lw, beq, jal, jr
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    req(4'd2, 5'd29, 5'd4, 5'd0, 16'h0008, 26'h0);
    a_valid = 1'b1;
    @(negedge clk);
    chk_a_wr("t2_lw", 10'd0, 32'h8FA4_0008);
    req(4'd4, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    @(negedge clk);
    chk_a_wr("t2_beq", 10'd1, 32'h1022_FFFF);
    req(4'd7, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0C00);
    @(negedge clk);
    chk_a_wr("t2_jal", 10'd2, 32'h0C00_0C00);
    req(4'd8, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    chk_a_wr("t2_jr", 10'd3, 32'h03E0_0008);
    a_valid = 1'b0;
    @(negedge clk);
    chk("t2_cnt", 64'(a_cnt), 64'd4);
`endif

    // 3: illegal kind, then clear
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    req(4'd6, 5'd0, 5'd1, 5'd0, 16'h0001, 26'h0);
    a_valid = 1'b1;
    @(negedge clk);
    chk_a_wr("t3_ori1", 10'd0, 32'h3401_0001);
    req(4'd12, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    #1 chk("t3_ill_rdy", 64'(a_rdy), 64'd1);
    @(negedge clk);
    chk("t3_ill_we", 64'(a_we), 64'd0);
    chk("t3_ill_err", 64'(a_err), 64'd1);
    chk("t3_ill_cnt", 64'(a_cnt), 64'd1);
    req(4'd6, 5'd0, 5'd1, 5'd0, 16'h0002, 26'h0);
    @(negedge clk);
    chk_a_wr("t3_ori2", 10'd1, 32'h3401_0002);
    a_valid = 1'b0;
    @(negedge clk);
    chk("t3_err_sticky", 64'(a_err), 64'd1);
    chk("t3_cnt2", 64'(a_cnt), 64'd2);
    a_clr = 1'b1;
    #1 chk("t3_clr_rdy", 64'(a_rdy), 64'd0);
    @(negedge clk);
    a_clr = 1'b0;
    chk("t3_clr_err", 64'(a_err), 64'd0);
    chk("t3_clr_cnt", 64'(a_cnt), 64'd0);
    chk("t3_clr_we", 64'(a_we), 64'd0);
    req(4'd6, 5'd0, 5'd1, 5'd0, 16'h0003, 26'h0);
    a_valid = 1'b1;
    @(negedge clk);
    chk_a_wr("t3_ori3", 10'd0, 32'h3401_0003);
    a_valid = 1'b0;

    // 4: ADDR_W=2 fill, stall, clear with valid
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    b_valid = 1'b1;
    @(negedge clk);
    chk("t4_w0_we", 64'(b_we), 64'd1);
    chk("t4_w0_addr", 64'(b_addr), 64'd0);
    chk("t4_w0_data", 64'(b_wdata), 64'h0022_1821);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t4_w3_we", 64'(b_we), 64'd1);
    chk("t4_w3_addr", 64'(b_addr), 64'd3);
    chk("t4_full_cnt", 64'(b_cnt), 64'd4);
    chk("t4_full", 64'(b_full), 64'd1);
    chk("t4_full_rdy", 64'(b_rdy), 64'd0);
    @(negedge clk);
    chk("t4_stall_we", 64'(b_we), 64'd0);
    chk("t4_stall_cnt", 64'(b_cnt), 64'd4);
    b_clr = 1'b1;
    #1 chk("t4_clr_rdy", 64'(b_rdy), 64'd0);
    @(negedge clk);
    chk("t4_clr_cnt", 64'(b_cnt), 64'd0);
    chk("t4_clr_full", 64'(b_full), 64'd0);
    chk("t4_clr_we", 64'(b_we), 64'd0);
    b_clr = 1'b0;
    #1 chk("t4_post_rdy", 64'(b_rdy), 64'd1);
    @(negedge clk);
    chk("t4_post_we", 64'(b_we), 64'd1);
    chk("t4_post_addr", 64'(b_addr), 64'd0);
    chk("t4_post_cnt", 64'(b_cnt), 64'd1);

    // 6b: 3 words used, branch vs non-branch
    @(negedge clk);
    @(negedge clk);
    chk("t6b_cnt3", 64'(b_cnt), 64'd3);
    req(4'd4, 5'd1, 5'd2, 5'd0, 16'h0010, 26'h0);
`ifdef INSTR_ENCODER_DELAY_SLOT_NOP_EN
    #1 chk("t6b_beq_rdy", 64'(b_rdy), 64'd0);
`else
    #1 chk("t6b_beq_rdy", 64'(b_rdy), 64'd1);
`endif
    req(4'd6, 5'd0, 5'd1, 5'd0, 16'h00AA, 26'h0);
    #1 chk("t6b_ori_rdy", 64'(b_rdy), 64'd1);
    @(negedge clk);
    b_valid = 1'b0;
    chk("t6b_ori_addr", 64'(b_addr), 64'd3);
    chk("t6b_ori_data", 64'(b_wdata), 64'h3401_00AA);
    chk("t6b_full", 64'(b_full), 64'd1);

    // 5: async reset mid-stream
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    a_valid = 1'b1;
    @(posedge clk);
    #2 chk("t5_pre_we", 64'(a_we), 64'd1);
    reset = 1'b0;
    #1;
    chk("t5_we", 64'(a_we), 64'd0);
    chk("t5_addr", 64'(a_addr), 64'd0);
    chk("t5_wdata", 64'(a_wdata), 64'd0);
    chk("t5_cnt", 64'(a_cnt), 64'd0);
    chk("t5_err", 64'(a_err), 64'd0);
    chk("t5_b_full", 64'(b_full), 64'd0);
    @(negedge clk);
    a_valid = 1'b0;
    reset = 1'b1;

    // 6a: beq then addu
    @(negedge clk);
    req(4'd4, 5'd1, 5'd2, 5'd0, 16'h0010, 26'h0);
    a_valid = 1'b1;
    @(negedge clk);
    chk_a_wr("t6_beq", 10'd0, 32'h1022_0010);
    req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
`ifdef INSTR_ENCODER_DELAY_SLOT_NOP_EN
    #1 chk("t6_pad_rdy", 64'(a_rdy), 64'd0);
    @(negedge clk);
    chk_a_wr("t6_nop", 10'd1, 32'h0000_0000);
    @(negedge clk);
    chk_a_wr("t6_addu", 10'd2, 32'h0022_1821);
    a_valid = 1'b0;
    @(negedge clk);
    chk("t6_cnt", 64'(a_cnt), 64'd3);
`else
    #1 chk("t6_nopad_rdy", 64'(a_rdy), 64'd1);
    @(negedge clk);
    chk_a_wr("t6_addu", 10'd1, 32'h0022_1821);
    a_valid = 1'b0;
    @(negedge clk);
    chk("t6_cnt", 64'(a_cnt), 64'd2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
